// File: rtl/note_chart_sequencer_if.sv
// Spawn-event handshake between the chart sequencer (master) and the lane renderers (slave).
// The master holds spawn_lanes steady while spawn_valid is high and spawn_ready is low.
interface note_chart_sequencer_if #(
  parameter int NUM_LANES = 4
) ();
  logic                 spawn_valid;
  logic [NUM_LANES-1:0] spawn_lanes;
  logic                 spawn_ready;

  modport master (output spawn_valid, output spawn_lanes, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_lanes, output spawn_ready);
endinterface

// File: rtl/note_chart_sequencer.sv
// Walks a {lanes, delta} note chart in a synchronous ROM, waits each entry's frame delay,
// then offers the lane mask over a valid/ready spawn interface.
module note_chart_sequencer #(
  parameter  int NUM_LANES   = 4,
  parameter  int DELTA_W     = 8,
  parameter  int CHART_DEPTH = 64,
  localparam int ADDR_W      = $clog2(CHART_DEPTH),
  localparam int ENTRY_W     = NUM_LANES + DELTA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                pause_i,
  output logic [ADDR_W-1:0]   chart_addr_o,
  input  logic [ENTRY_W-1:0]  chart_data_i,
  note_chart_sequencer_if.master spawn_if,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W:0]     spawn_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COUNT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   valid_q;
  logic [NUM_LANES-1:0]   lanes_q;
  logic [ADDR_W:0]        count_q;
  logic [ADDR_W:0]        count_d;
  logic [DELTA_W-1:0]     cnt_q;
  logic                   busy_q;
  logic                   done_q;

  logic [NUM_LANES-1:0]   entry_lanes;
  logic [DELTA_W-1:0]     entry_delta;
  logic                   last_entry;

  assign entry_lanes = chart_data_i[ENTRY_W-1:DELTA_W];
  assign entry_delta = chart_data_i[DELTA_W-1:0];
  assign last_entry  = (addr_q == ADDR_W'(CHART_DEPTH - 1));
  // Accepted-spawn counter sticks at all-ones rather than wrapping.
  assign count_d     = (count_q == '1) ? count_q : count_q + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      lanes_q <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (stop_i) begin
      // Abort outranks start and an in-flight accept; the accept is dropped uncounted.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            addr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (entry_lanes == '0 && entry_delta == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lanes_q <= entry_lanes;
            cnt_q   <= entry_delta;
            if (entry_delta == '0) begin
              state_q <= S_EMIT;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (frame_tick_i && !pause_i) begin
            cnt_q <= cnt_q - DELTA_W'(1);
            if (cnt_q == DELTA_W'(1)) begin
              state_q <= S_EMIT;
              valid_q <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (spawn_if.spawn_ready) begin
            valid_q <= 1'b0;
            count_q <= count_d;
            if (last_entry) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign chart_addr_o         = addr_q;
  assign spawn_if.spawn_valid = valid_q;
  assign spawn_if.spawn_lanes = lanes_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign spawn_count_o        = count_q;

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Directed bench for note_chart_sequencer: behavioural chart ROM, one task per scenario,
// inline comparisons against hand-computed values.
module tb_note_chart_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        pause_i = 1'b0;
  logic [5:0]  chart_addr_o;
  logic [11:0] chart_data_i;
  logic        busy_o;
  logic        done_o;
  logic [6:0]  spawn_count_o;

  logic [11:0] rom [64];
  int checks = 0;
  int errors = 0;

  note_chart_sequencer_if #(.NUM_LANES(4)) sif ();

  note_chart_sequencer #(
    .NUM_LANES(4), .DELTA_W(8), .CHART_DEPTH(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick_i), .start_i(start_i),
    .stop_i(stop_i), .pause_i(pause_i), .chart_addr_o(chart_addr_o),
    .chart_data_i(chart_data_i), .spawn_if(sif), .busy_o(busy_o),
    .done_o(done_o), .spawn_count_o(spawn_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) chart_data_i <= rom[chart_addr_o];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 12'h000;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick_i = 1'b1;
    step();
    frame_tick_i = 1'b0;
  endtask

  // Steps until done_o, counting accepts and checking each offered mask against the ROM.
  task automatic run_until_done(input int budget, output int spawns, output bit ok);
    spawns = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      if (sif.spawn_valid && sif.spawn_ready) begin
        checks++;
        if (sif.spawn_lanes !== rom[spawns][11:8]) begin
          errors++;
          $display("FAIL run_lanes[%0d] got %b exp %b", spawns, sif.spawn_lanes, rom[spawns][11:8]);
        end
        spawns++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_rom();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({sif.spawn_valid, busy_o, done_o, chart_addr_o, spawn_count_o, sif.spawn_lanes} !== 21'd0) begin
      errors++;
      $display("FAIL reset_init got v%b b%b d%b a%0d c%0d l%b exp all 0", sif.spawn_valid,
               busy_o, done_o, chart_addr_o, spawn_count_o, sif.spawn_lanes);
    end
    rst_n = 1'b1;
    step();
    rom[0] = {4'b1000, 8'd200};
    pulse_start();
    step();
    step();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_in_count got %b exp 1", busy_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sif.spawn_valid, busy_o, done_o, chart_addr_o, spawn_count_o, sif.spawn_lanes} !== 21'd0) begin
      errors++;
      $display("FAIL reset_async got v%b b%b d%b a%0d c%0d l%b exp all 0", sif.spawn_valid,
               busy_o, done_o, chart_addr_o, spawn_count_o, sif.spawn_lanes);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) pulse_tick();
    checks++;
    if ({sif.spawn_valid, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_resume got v%b b%b d%b exp 000", sif.spawn_valid, busy_o, done_o);
    end
  endtask

  task automatic test_single_spawn();
    clear_rom();
    rom[0] = {4'b0101, 8'd0};
    sif.spawn_ready = 1'b1;
    pulse_start();
    step();
    checks++;
    if (sif.spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid got %b exp 0", sif.spawn_valid);
    end
    step();
    checks++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_lanes !== 4'b0101) begin
      errors++;
      $display("FAIL single_offer got v%b l%b exp v1 l0101", sif.spawn_valid, sif.spawn_lanes);
    end
    step();
    checks++;
    if (sif.spawn_valid !== 1'b0 || spawn_count_o !== 7'd1) begin
      errors++;
      $display("FAIL single_accept got v%b c%0d exp v0 c1", sif.spawn_valid, spawn_count_o);
    end
    step();
    step();
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done got d%b b%b exp d1 b0", done_o, busy_o);
    end
  endtask

  task automatic test_countdown_pause();
    clear_rom();
    rom[0] = {4'b1000, 8'd3};
    sif.spawn_ready = 1'b1;
    pulse_start();
    step();
    step();
    for (int i = 0; i < 4; i++) step();
    pulse_tick();
    pulse_tick();
    checks++;
    if (sif.spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL count_early got %b exp 0 after 2 ticks", sif.spawn_valid);
    end
    pulse_tick();
    checks++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_lanes !== 4'b1000) begin
      errors++;
      $display("FAIL count_third_tick got v%b l%b exp v1 l1000", sif.spawn_valid, sif.spawn_lanes);
    end
    step();
    step();
    step();
    pulse_start();
    step();
    step();
    pulse_tick();
    pause_i = 1'b1;
    pulse_tick();
    pulse_tick();
    pause_i = 1'b0;
    pulse_tick();
    checks++;
    if (sif.spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_early got %b exp 0 after 4 ticks (2 paused)", sif.spawn_valid);
    end
    pause_i = 1'b1;
    step();
    pause_i = 1'b0;
    pulse_tick();
    checks++;
    if (sif.spawn_valid !== 1'b1) begin
      errors++;
      $display("FAIL pause_release got %b exp 1 after 5th tick", sif.spawn_valid);
    end
    step();
    checks++;
    if (spawn_count_o !== 7'd1) begin
      errors++;
      $display("FAIL pause_count got %0d exp 1", spawn_count_o);
    end
    step();
    step();
  endtask

  task automatic test_backpressure();
    int stable_bad;
    clear_rom();
    rom[0] = {4'b0110, 8'd0};
    rom[1] = {4'b0011, 8'd0};
    sif.spawn_ready = 1'b0;
    pulse_start();
    step();
    step();
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      pause_i = i[0];
      if (sif.spawn_valid !== 1'b1 || sif.spawn_lanes !== 4'b0110 || chart_addr_o !== 6'd0)
        stable_bad++;
      step();
    end
    pause_i = 1'b0;
    checks++;
    if (stable_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", stable_bad);
    end
    sif.spawn_ready = 1'b1;
    step();
    sif.spawn_ready = 1'b0;
    checks++;
    if (sif.spawn_valid !== 1'b0 || spawn_count_o !== 7'd1 || chart_addr_o !== 6'd1) begin
      errors++;
      $display("FAIL bp_accept got v%b c%0d a%0d exp v0 c1 a1", sif.spawn_valid, spawn_count_o, chart_addr_o);
    end
    step();
    step();
    checks++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_lanes !== 4'b0011 || spawn_count_o !== 7'd1) begin
      errors++;
      $display("FAIL bp_second got v%b l%b c%0d exp v1 l0011 c1", sif.spawn_valid, sif.spawn_lanes, spawn_count_o);
    end
    sif.spawn_ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || spawn_count_o !== 7'd2) begin
      errors++;
      $display("FAIL marker_done got d%b b%b c%0d exp d1 b0 c2", done_o, busy_o, spawn_count_o);
    end
  endtask

  task automatic test_full_chart();
    int spawns;
    bit ok;
    clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = {4'((i % 15) + 1), 8'(i % 3)};
    sif.spawn_ready = 1'b1;
    pulse_start();
    frame_tick_i = 1'b1;
    run_until_done(2000, spawns, ok);
    frame_tick_i = 1'b0;
    checks++;
    if (ok !== 1'b1 || spawns !== 64) begin
      errors++;
      $display("FAIL full_run got done%b spawns %0d exp done1 spawns 64", ok, spawns);
    end
    step();
    step();
    checks++;
    if (spawn_count_o !== 7'd64 || chart_addr_o !== 6'd63 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL full_end got c%0d a%0d d%b b%b exp c64 a63 d1 b0", spawn_count_o, chart_addr_o, done_o, busy_o);
    end
  endtask

  task automatic test_stop();
    clear_rom();
    rom[0] = {4'b1001, 8'd0};
    rom[1] = {4'b0001, 8'd0};
    sif.spawn_ready = 1'b0;
    pulse_start();
    step();
    step();
    checks++;
    if (sif.spawn_valid !== 1'b1 || spawn_count_o !== 7'd0) begin
      errors++;
      $display("FAIL stop_setup got v%b c%0d exp v1 c0", sif.spawn_valid, spawn_count_o);
    end
    stop_i = 1'b1;
    sif.spawn_ready = 1'b1;
    step();
    stop_i = 1'b0;
    sif.spawn_ready = 1'b0;
    checks++;
    if ({sif.spawn_valid, busy_o, done_o} !== 3'b000 || spawn_count_o !== 7'd0) begin
      errors++;
      $display("FAIL stop_emit got v%b b%b d%b c%0d exp v0 b0 d0 c0", sif.spawn_valid, busy_o, done_o, spawn_count_o);
    end
    start_i = 1'b1;
    stop_i = 1'b1;
    step();
    start_i = 1'b0;
    stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_beats_start got busy %b exp 0", busy_o);
    end
    pulse_start();
    checks++;
    if (busy_o !== 1'b1 || chart_addr_o !== 6'd0) begin
      errors++;
      $display("FAIL replay_start got b%b a%0d exp b1 a0", busy_o, chart_addr_o);
    end
    step();
    step();
    checks++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_lanes !== 4'b1001) begin
      errors++;
      $display("FAIL replay_first got v%b l%b exp v1 l1001", sif.spawn_valid, sif.spawn_lanes);
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (sif.spawn_valid !== 1'b1 || chart_addr_o !== 6'd0) begin
      errors++;
      $display("FAIL start_while_busy got v%b a%0d exp v1 a0", sif.spawn_valid, chart_addr_o);
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  initial begin
    sif.spawn_ready = 1'b0;
    test_reset();
    test_single_spawn();
    test_countdown_pause();
    test_backpressure();
    test_full_chart();
    test_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
